// File: rtl/pwm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : pwm_pkg
//  Purpose : Shared definitions for the PWM ramp sequencer: register map of
//            the two-channel PWM slave and the ramp engine state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pwm_pkg;

  // PWM slave register map (byte addresses)
  localparam logic [7:0] CTRL_1 = 8'h00;
  localparam logic [7:0] DIV_1  = 8'h04;
  localparam logic [7:0] PER_1  = 8'h08;
  localparam logic [7:0] DC_1   = 8'h0C;
  localparam logic [7:0] CTRL_2 = 8'h10;
  localparam logic [7:0] DIV_2  = 8'h14;
  localparam logic [7:0] PER_2  = 8'h18;
  localparam logic [7:0] DC_2   = 8'h1C;

  // Ramp engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } ramp_state_e;

  // Duty-cycle register address for a channel select bit
  function automatic logic [7:0] dc_addr(input logic ch);
    return ch ? DC_2 : DC_1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : pwm_bus_arbiter
//  Purpose : Fixed-priority, purely combinational mux of the PWM register
//            bus. The host always wins; the ramp engine gets the bus only in
//            cycles where the host is not requesting. Idle bus drives zeros.
//  Ports   : host_*_i   host request/attributes
//            ramp_*_i   ramp engine request/attributes
//            host_gnt_o host owns the bus this cycle
//            ramp_gnt_o ramp engine owns the bus this cycle
//            write_o/addr_o/wdata_o  muxed PWM bus outputs
//  Rev     : 1.0  initial release
// ============================================================================
module pwm_bus_arbiter #(
  parameter int AW = 8,
  parameter int BW = 32
) (
  input  logic          host_req_i,
  input  logic          host_write_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [BW-1:0] host_wdata_i,
  input  logic          ramp_req_i,
  input  logic          ramp_write_i,
  input  logic [AW-1:0] ramp_addr_i,
  input  logic [BW-1:0] ramp_wdata_i,
  output logic          host_gnt_o,
  output logic          ramp_gnt_o,
  output logic          write_o,
  output logic [AW-1:0] addr_o,
  output logic [BW-1:0] wdata_o
);

  always_comb begin
    host_gnt_o = host_req_i;
    ramp_gnt_o = ramp_req_i & ~host_req_i;
    write_o    = 1'b0;
    addr_o     = '0;
    wdata_o    = '0;
    if (host_req_i) begin
      write_o = host_write_i;
      addr_o  = host_addr_i;
      wdata_o = host_wdata_i;
    end else if (ramp_req_i) begin
      write_o = ramp_write_i;
      addr_o  = ramp_addr_i;
      wdata_o = ramp_wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : pwm_ramp_sequencer
//  Purpose : Bus master in front of the two-channel PWM slave. Soft-starts /
//            soft-stops a channel by ramping its duty-cycle register from the
//            current value to a target in fixed steps at a fixed interval, and
//            shares the single register bus with a higher-priority host.
//  Ports   : clk_i, rst_i            clock, synchronous active-high reset
//            host_*                  host bus access (single-cycle accesses)
//            ramp_start_i/ch/target/step/interval  ramp command
//            ramp_busy_o/done_o/abort_o            ramp status
//            write_o/addr_o/wdata_o/rdata_i        PWM register bus
//  Rev     : 1.0  initial release
// ============================================================================
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int BW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          host_req_i,
  input  logic          host_write_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [BW-1:0] host_wdata_i,
  output logic          host_gnt_o,
  output logic [BW-1:0] host_rdata_o,
  input  logic          ramp_start_i,
  input  logic          ramp_ch_i,
  input  logic [DW-1:0] ramp_target_i,
  input  logic [DW-1:0] ramp_step_i,
  input  logic [DW-1:0] ramp_interval_i,
  output logic          ramp_busy_o,
  output logic          ramp_done_o,
  output logic          ramp_abort_o,
  output logic          write_o,
  output logic [AW-1:0] addr_o,
  output logic [BW-1:0] wdata_o,
  input  logic [BW-1:0] rdata_i
);

  ramp_state_e   state_q, state_d;
  logic          ch_q, ch_d;
  logic [DW-1:0] target_q, target_d;
  logic [DW-1:0] step_q, step_d;
  logic [DW-1:0] interval_q, interval_d;
  logic [DW-1:0] cur_q, cur_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          abort_q, abort_d;

  logic          ramp_req;
  logic          ramp_write;
  logic          ramp_gnt;
  logic [AW-1:0] ramp_addr;
  logic [BW-1:0] ramp_wdata;
  logic          host_abort;
  logic [DW-1:0] nxt;
  logic [DW:0]   sum;
  logic [DW:0]   diff;

  // Only the low DW bits of a duty register are meaningful to the ramp.
  logic          unused_rdata_hi;
  assign unused_rdata_hi = ^rdata_i[BW-1:DW];

  assign host_rdata_o = rdata_i;
  assign ramp_busy_o  = (state_q != IDLE);
  assign ramp_done_o  = done_q;
  assign ramp_abort_o = abort_q;
  assign ramp_addr    = AW'(dc_addr(ch_q));

  // A host write to the duty register being ramped wins the register outright.
  assign host_abort = host_req_i & host_write_i & (host_addr_i == ramp_addr)
                      & (state_q != IDLE);

  // Next step value, clamped to the target in both directions. The extra bit
  // catches overflow on the way up and borrow on the way down.
  always_comb begin
    sum  = {1'b0, cur_q} + {1'b0, step_q};
    diff = {1'b0, cur_q} - {1'b0, step_q};
    nxt  = target_q;
    if (cur_q < target_q) begin
      nxt = (sum >= {1'b0, target_q}) ? target_q : sum[DW-1:0];
    end else if (cur_q > target_q) begin
      nxt = (diff[DW] || (diff[DW-1:0] <= target_q)) ? target_q : diff[DW-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    ramp_req   = 1'b0;
    ramp_write = 1'b0;
    ramp_wdata = '0;

    case (state_q)
      IDLE: begin
        if (ramp_start_i) begin
          ch_d       = ramp_ch_i;
          target_d   = ramp_target_i;
          step_d     = (ramp_step_i == '0) ? DW'(1) : ramp_step_i;
          interval_d = (ramp_interval_i == '0) ? DW'(1) : ramp_interval_i;
          state_d    = READ;
        end
      end
      READ: begin
        ramp_req = 1'b1;
        if (ramp_gnt) begin
          cur_d = rdata_i[DW-1:0];
          if (rdata_i[DW-1:0] == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = interval_q;
          end
        end
      end
      WAIT: begin
        // cnt is loaded with the interval on entry, so WAIT spans exactly
        // interval cycles.
        if (cnt_q <= DW'(1)) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      WRITE: begin
        ramp_req   = 1'b1;
        ramp_write = 1'b1;
        ramp_wdata = BW'(nxt);
        if (ramp_gnt) begin
          cur_d = nxt;
          if (nxt == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = interval_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (host_abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ch_q       <= 1'b0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  pwm_bus_arbiter #(
    .AW (AW),
    .BW (BW)
  ) u_arbiter (
    .host_req_i   (host_req_i),
    .host_write_i (host_write_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .ramp_req_i   (ramp_req),
    .ramp_write_i (ramp_write),
    .ramp_addr_i  (ramp_addr),
    .ramp_wdata_i (ramp_wdata),
    .host_gnt_o   (host_gnt_o),
    .ramp_gnt_o   (ramp_gnt),
    .write_o      (write_o),
    .addr_o       (addr_o),
    .wdata_o      (wdata_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_pwm_ramp_sequencer
//  Purpose : Self-checking bench for pwm_ramp_sequencer with a behavioural
//            PWM register slave and a queue of expected ramp bus writes.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pwm_ramp_sequencer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          host_req_i, host_write_i;
  logic [AW-1:0] host_addr_i;
  logic [BW-1:0] host_wdata_i;
  logic          host_gnt_o;
  logic [BW-1:0] host_rdata_o;
  logic          ramp_start_i, ramp_ch_i;
  logic [DW-1:0] ramp_target_i, ramp_step_i, ramp_interval_i;
  logic          ramp_busy_o, ramp_done_o, ramp_abort_o;
  logic          write_o;
  logic [AW-1:0] addr_o;
  logic [BW-1:0] wdata_o;
  logic [BW-1:0] rdata_i;

  always #5 clk_i = ~clk_i;

  pwm_ramp_sequencer #(.DW(DW), .AW(AW), .BW(BW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .host_req_i      (host_req_i),
    .host_write_i    (host_write_i),
    .host_addr_i     (host_addr_i),
    .host_wdata_i    (host_wdata_i),
    .host_gnt_o      (host_gnt_o),
    .host_rdata_o    (host_rdata_o),
    .ramp_start_i    (ramp_start_i),
    .ramp_ch_i       (ramp_ch_i),
    .ramp_target_i   (ramp_target_i),
    .ramp_step_i     (ramp_step_i),
    .ramp_interval_i (ramp_interval_i),
    .ramp_busy_o     (ramp_busy_o),
    .ramp_done_o     (ramp_done_o),
    .ramp_abort_o    (ramp_abort_o),
    .write_o         (write_o),
    .addr_o          (addr_o),
    .wdata_o         (wdata_o),
    .rdata_i         (rdata_i)
  );

  // Behavioural PWM slave: eight 32-bit registers, combinational read.
  logic [BW-1:0] mem [0:7];
  assign rdata_i = (addr_o < 8'h20) ? mem[addr_o[4:2]] : '0;
  always @(posedge clk_i) if (write_o) mem[addr_o[4:2]] <= wdata_o;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;
  int          last_wr_cyc = 0;
  int          wr_cyc[$];
  logic [39:0] exp_q[$];

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ramp-side bus monitor: every ramp write must match the head of the queue.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (ramp_done_o) begin
        done_cnt++;
        chk("busy_low_with_done", ramp_busy_o, 0);
      end
      if (ramp_abort_o) abort_cnt++;
      if (write_o && !host_gnt_o) begin
        wr_cyc.push_back(cyc);
        last_wr_cyc = cyc;
        chk("ramp_write_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("ramp_write", {addr_o, wdata_o}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
    host_req_i = 1; host_write_i = 1; host_addr_i = a; host_wdata_i = d;
    @(negedge clk_i);
    chk("host_gnt", host_gnt_o, 1);
    chk("host_addr_pass", addr_o, a);
    step();
    host_req_i = 0; host_write_i = 0; host_addr_i = '0; host_wdata_i = '0;
  endtask

  task automatic start_ramp(input logic ch, input int tgt, input int stp, input int intv);
    ramp_start_i = 1; ramp_ch_i = ch;
    ramp_target_i = DW'(tgt); ramp_step_i = DW'(stp); ramp_interval_i = DW'(intv);
    step();
    ramp_start_i = 0;
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_i);
      if (!ramp_busy_o) begin seen = 1; break; end
    end
    chk("ramp_finish_in_budget", seen, 1);
    step();
    step();
  endtask

  function automatic logic [39:0] wr(input logic [7:0] a, input int d);
    return {a, 32'(d)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, hold_end;
    bit seen;
    host_req_i = 0; host_write_i = 0; host_addr_i = '0; host_wdata_i = '0;
    ramp_start_i = 0; ramp_ch_i = 0; ramp_target_i = '0; ramp_step_i = '0; ramp_interval_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", ramp_busy_o, 0);
    chk("rst_done", ramp_done_o, 0);
    chk("rst_abort", ramp_abort_o, 0);
    chk("rst_write", write_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    step();
    rst_i = 0;

    // 1: ch0 0 -> 10, step 4, interval 3
    host_wr(8'h0C, 0);
    d0 = done_cnt; wr_cyc.delete();
    exp_q.push_back(wr(8'h0C, 4)); exp_q.push_back(wr(8'h0C, 8)); exp_q.push_back(wr(8'h0C, 10));
    start_ramp(0, 10, 4, 3);
    wait_idle(100);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_write_count", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      chk("t1_spacing_a", wr_cyc[1] - wr_cyc[0], 4);
      chk("t1_spacing_b", wr_cyc[2] - wr_cyc[1], 4);
    end
    chk("t1_dc1", mem[3], 10);

    // 2: ch1 100 -> 90, step 50: single clamped write, no underflow
    host_wr(8'h1C, 100);
    d0 = done_cnt; wr_cyc.delete();
    exp_q.push_back(wr(8'h1C, 90));
    start_ramp(1, 90, 50, 1);
    wait_idle(50);
    chk("t2_done_once", done_cnt - d0, 1);
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_write_count", wr_cyc.size(), 1);
    chk("t2_dc2", mem[7], 90);

    // 3: host holds the bus for 5 cycles across the ramp WRITE
    d0 = done_cnt;
    exp_q.push_back(wr(8'h0C, 20));
    start_ramp(0, 20, 10, 2);
    step();
    step();
    host_req_i = 1; host_write_i = 0; host_addr_i = 8'h00;
    hold_end = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t3_host_gnt", host_gnt_o, 1);
      chk("t3_no_write_while_host", write_o, 0);
      hold_end = cyc;
      step();
    end
    host_req_i = 0;
    wait_idle(50);
    chk("t3_write_first_free_cycle", last_wr_cyc, hold_end + 1);
    chk("t3_done_once", done_cnt - d0, 1);
    chk("t3_queue_empty", exp_q.size(), 0);
    chk("t3_dc1", mem[3], 20);

    // 4a: host write to the ramped channel aborts it
    d0 = done_cnt; a0 = abort_cnt;
    exp_q.push_back(wr(8'h0C, 30));
    start_ramp(0, 60, 10, 3);
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) begin seen = 1; break; end
    end
    chk("t4_first_write_in_budget", seen, 1);
    step();
    host_wr(8'h0C, 5);
    @(negedge clk_i);
    chk("t4_abort_pulse", ramp_abort_o, 1);
    chk("t4_busy_after_abort", ramp_busy_o, 0);
    repeat (20) step();
    chk("t4_abort_once", abort_cnt - a0, 1);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_dc1_host_value", mem[3], 5);

    // 4b: host write to the other channel leaves the ramp alone
    d0 = done_cnt; a0 = abort_cnt;
    exp_q.push_back(wr(8'h0C, 15)); exp_q.push_back(wr(8'h0C, 25));
    start_ramp(0, 25, 10, 2);
    step();
    host_wr(8'h1C, 33);
    wait_idle(50);
    chk("t4b_done_once", done_cnt - d0, 1);
    chk("t4b_no_abort", abort_cnt - a0, 0);
    chk("t4b_queue_empty", exp_q.size(), 0);
    chk("t4b_dc1", mem[3], 25);
    chk("t4b_dc2", mem[7], 33);

    // 5a: already at target -> done after READ, no writes
    host_wr(8'h0C, 7);
    d0 = done_cnt; wr_cyc.delete();
    start_ramp(0, 7, 3, 1);
    wait_idle(20);
    chk("t5a_done_once", done_cnt - d0, 1);
    chk("t5a_no_writes", wr_cyc.size(), 0);
    chk("t5a_dc1", mem[3], 7);

    // 5b: step 0 and interval 0 behave as 1
    host_wr(8'h0C, 0);
    d0 = done_cnt; wr_cyc.delete();
    exp_q.push_back(wr(8'h0C, 1)); exp_q.push_back(wr(8'h0C, 2)); exp_q.push_back(wr(8'h0C, 3));
    start_ramp(0, 3, 0, 0);
    wait_idle(50);
    chk("t5b_done_once", done_cnt - d0, 1);
    chk("t5b_queue_empty", exp_q.size(), 0);
    chk("t5b_write_count", wr_cyc.size(), 3);
    chk("t5b_dc1", mem[3], 3);

    // 6a: reset during WAIT
    wr_cyc.delete();
    start_ramp(0, 100, 1, 5);
    step();
    rst_i = 1;
    step();
    rst_i = 0;
    @(negedge clk_i);
    chk("t6_busy_after_rst", ramp_busy_o, 0);
    chk("t6_done_after_rst", ramp_done_o, 0);
    chk("t6_write_after_rst", write_o, 0);
    repeat (12) step();
    chk("t6_no_writes", wr_cyc.size(), 0);
    chk("t6_dc1", mem[3], 3);

    // 6b: start while busy is ignored
    d0 = done_cnt;
    exp_q.push_back(wr(8'h0C, 4)); exp_q.push_back(wr(8'h0C, 5));
    start_ramp(0, 5, 1, 2);
    step();
    ramp_start_i = 1; ramp_ch_i = 1; ramp_target_i = '0; ramp_step_i = 16'd1; ramp_interval_i = 16'd1;
    step();
    ramp_start_i = 0;
    wait_idle(50);
    chk("t6b_done_once", done_cnt - d0, 1);
    chk("t6b_queue_empty", exp_q.size(), 0);
    chk("t6b_dc1", mem[3], 5);
    chk("t6b_dc2_untouched", mem[7], 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
